// File: rtl/muldiv_unit_if.sv
// Request/response port group between the core and the shared mul/div engine.
interface muldiv_unit_if #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned HART_ID_W  = 1,
    parameter int unsigned REG_ADDR_W = 5
);
    logic                  muldiv_start;
    logic [2:0]            muldiv_op;
    logic [XLEN-1:0]       muldiv_a;
    logic [XLEN-1:0]       muldiv_b;
    logic [HART_ID_W-1:0]  muldiv_hart_id;
    logic [REG_ADDR_W-1:0] muldiv_rd;
    logic                  muldiv_busy;
    logic                  muldiv_done;
    logic [XLEN-1:0]       muldiv_result;
    logic [HART_ID_W-1:0]  muldiv_done_hart_id;
    logic [REG_ADDR_W-1:0] muldiv_done_rd;

    // Issuing side (core).
    modport master (
        output muldiv_start, muldiv_op, muldiv_a, muldiv_b, muldiv_hart_id, muldiv_rd,
        input  muldiv_busy, muldiv_done, muldiv_result, muldiv_done_hart_id, muldiv_done_rd
    );

    // Engine side.
    modport slave (
        input  muldiv_start, muldiv_op, muldiv_a, muldiv_b, muldiv_hart_id, muldiv_rd,
        output muldiv_busy, muldiv_done, muldiv_result, muldiv_done_hart_id, muldiv_done_rd
    );
endinterface

// File: rtl/muldiv_unit.sv
// Shared iterative RV32M multiply/divide engine: one bit per cycle over operand magnitudes,
// sign fix-up on the final edge, fast path for divide-by-zero and signed overflow.
module muldiv_unit #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned HART_ID_W  = 1,
    parameter int unsigned REG_ADDR_W = 5
) (
    input logic         clk,
    input logic         rst_n,
    muldiv_unit_if.slave bus
);
    localparam int unsigned CntW = $clog2(XLEN);

    localparam logic [2:0] OpMul    = 3'd0;
    localparam logic [2:0] OpMulh   = 3'd1;
    localparam logic [2:0] OpMulhsu = 3'd2;
    localparam logic [2:0] OpDiv    = 3'd4;
    localparam logic [2:0] OpRem    = 3'd6;

    localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [2:0]            op_q, op_d;
    logic                  neg_q, neg_d;
    // Multiplicand magnitude for multiplies, divisor magnitude for divides.
    logic [XLEN-1:0]       opnd_q, opnd_d;
    // Multiply: {partial high, multiplier shifting out}. Divide: {remainder, dividend/quotient}.
    logic [2*XLEN-1:0]     acc_q, acc_d;
    logic [HART_ID_W-1:0]  hart_q, hart_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic [XLEN-1:0]       result_q, result_d;
    logic [HART_ID_W-1:0]  done_hart_q, done_hart_d;
    logic [REG_ADDR_W-1:0] done_rd_q, done_rd_d;

    // Accept-side decode of the incoming request.
    logic            is_div, signed_a, signed_b, a_neg, b_neg, neg_in;
    logic            div_by_zero, div_ovf, fast_path;
    logic [XLEN-1:0] mag_a, mag_b, fast_result;

    // Per-iteration datapath and final sign correction.
    logic [XLEN:0]     mul_sum, div_rem_sh, div_diff;
    logic              div_ok;
    logic [2*XLEN-1:0] mul_next, div_next, iter_next, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, final_result;

    // Decode signedness, magnitudes and fast-path results of the request on the bus.
    always_comb begin
        is_div   = bus.muldiv_op[2];
        signed_a = (bus.muldiv_op == OpMulh) || (bus.muldiv_op == OpMulhsu) ||
                   (bus.muldiv_op == OpDiv)  || (bus.muldiv_op == OpRem);
        signed_b = (bus.muldiv_op == OpMulh) || (bus.muldiv_op == OpDiv) ||
                   (bus.muldiv_op == OpRem);
        a_neg    = signed_a & bus.muldiv_a[XLEN-1];
        b_neg    = signed_b & bus.muldiv_b[XLEN-1];
        mag_a    = a_neg ? -bus.muldiv_a : bus.muldiv_a;
        mag_b    = b_neg ? -bus.muldiv_b : bus.muldiv_b;
        // Remainder follows the dividend's sign; everything else follows the sign product.
        neg_in   = (is_div && bus.muldiv_op[1]) ? a_neg : (a_neg ^ b_neg);

        div_by_zero = is_div && (bus.muldiv_b == '0);
        div_ovf     = is_div && signed_b && (bus.muldiv_a == MinInt) && (bus.muldiv_b == '1);
        fast_path   = div_by_zero || div_ovf;
        if (div_by_zero) begin
            fast_result = bus.muldiv_op[1] ? bus.muldiv_a : '1;
        end else begin
            fast_result = bus.muldiv_op[1] ? '0 : bus.muldiv_a;
        end
    end

    // One shift-add / restoring-subtract step, plus sign fix-up and result select.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};

        div_rem_sh = acc_q[2*XLEN-1:XLEN-1];
        div_diff   = div_rem_sh - {1'b0, opnd_q};
        div_ok     = !div_diff[XLEN];
        div_next   = {(div_ok ? div_diff[XLEN-1:0] : div_rem_sh[XLEN-1:0]),
                      acc_q[XLEN-2:0], div_ok};

        iter_next = op_q[2] ? div_next : mul_next;

        prod_fix = neg_q ? -iter_next : iter_next;
        quo_fix  = neg_q ? -iter_next[XLEN-1:0] : iter_next[XLEN-1:0];
        rem_fix  = neg_q ? -iter_next[2*XLEN-1:XLEN] : iter_next[2*XLEN-1:XLEN];

        if (!op_q[2]) begin
            final_result = (op_q == OpMul) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end else begin
            final_result = op_q[1] ? rem_fix : quo_fix;
        end
    end

    // Next-state logic: accept in idle, iterate XLEN times, present result for one cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        neg_d       = neg_q;
        opnd_d      = opnd_q;
        acc_d       = acc_q;
        hart_d      = hart_q;
        rd_d        = rd_q;
        result_d    = result_q;
        done_hart_d = done_hart_q;
        done_rd_d   = done_rd_q;

        unique case (state_q)
            StIdle: begin
                if (bus.muldiv_start) begin
                    op_d   = bus.muldiv_op;
                    neg_d  = neg_in;
                    hart_d = bus.muldiv_hart_id;
                    rd_d   = bus.muldiv_rd;
                    cnt_d  = '0;
                    if (fast_path) begin
                        result_d    = fast_result;
                        done_hart_d = bus.muldiv_hart_id;
                        done_rd_d   = bus.muldiv_rd;
                        state_d     = StDone;
                    end else begin
                        opnd_d  = is_div ? mag_b : mag_a;
                        acc_d   = {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                acc_d = iter_next;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(XLEN - 1)) begin
                    result_d    = final_result;
                    done_hart_d = hart_q;
                    done_rd_d   = rd_q;
                    state_d     = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            op_q        <= '0;
            neg_q       <= 1'b0;
            opnd_q      <= '0;
            acc_q       <= '0;
            hart_q      <= '0;
            rd_q        <= '0;
            result_q    <= '0;
            done_hart_q <= '0;
            done_rd_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            neg_q       <= neg_d;
            opnd_q      <= opnd_d;
            acc_q       <= acc_d;
            hart_q      <= hart_d;
            rd_q        <= rd_d;
            result_q    <= result_d;
            done_hart_q <= done_hart_d;
            done_rd_q   <= done_rd_d;
        end
    end

    assign bus.muldiv_busy         = (state_q != StIdle);
    assign bus.muldiv_done         = (state_q == StDone);
    assign bus.muldiv_result       = result_q;
    assign bus.muldiv_done_hart_id = done_hart_q;
    assign bus.muldiv_done_rd      = done_rd_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: arithmetic reference model plus cycle-level timing model.
module tb_muldiv_unit;
    logic clk;
    logic rst_n;

    int vectors;
    int miscompares;

    muldiv_unit_if #(.XLEN(32), .HART_ID_W(1), .REG_ADDR_W(5)) bus ();

    muldiv_unit #(.XLEN(32), .HART_ID_W(1), .REG_ADDR_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RV32M result computed with plain 64-bit arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint     sa;
        longint     sb;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        p  = '0;
        case (op)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'h0) return a;
                p = sa % sb;
                return p[31:0];
            end
            default: begin
                if (b == 32'h0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic bit is_fast(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        if (!op[2]) return 1'b0;
        if (b == 32'h0) return 1'b1;
        return ((op == 3'd4) || (op == 3'd6)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Timing model: m_left counts remaining busy cycles; done is the last of them.
    int          m_left;
    logic [31:0] m_pend;
    logic        m_phart;
    logic [4:0]  m_prd;
    logic [31:0] m_res;
    logic        m_hart;
    logic [4:0]  m_rd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0;
            m_pend <= '0;
            m_phart <= 1'b0;
            m_prd  <= '0;
            m_res  <= '0;
            m_hart <= 1'b0;
            m_rd   <= '0;
        end else if (m_left != 0) begin
            m_left <= m_left - 1;
            if (m_left == 2) begin
                m_res  <= m_pend;
                m_hart <= m_phart;
                m_rd   <= m_prd;
            end
        end else if (bus.muldiv_start) begin
            m_pend  <= ref_result(bus.muldiv_op, bus.muldiv_a, bus.muldiv_b);
            m_phart <= bus.muldiv_hart_id;
            m_prd   <= bus.muldiv_rd;
            if (is_fast(bus.muldiv_op, bus.muldiv_a, bus.muldiv_b)) begin
                m_left <= 1;
                m_res  <= ref_result(bus.muldiv_op, bus.muldiv_a, bus.muldiv_b);
                m_hart <= bus.muldiv_hart_id;
                m_rd   <= bus.muldiv_rd;
            end else begin
                m_left <= 33;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        chk("cyc_busy", {31'h0, bus.muldiv_busy}, {31'h0, (m_left != 0)});
        chk("cyc_done", {31'h0, bus.muldiv_done}, {31'h0, (m_left == 1)});
        chk("cyc_result", bus.muldiv_result, m_res);
        chk("cyc_hart", {31'h0, bus.muldiv_done_hart_id}, {31'h0, m_hart});
        chk("cyc_rd", {27'h0, bus.muldiv_done_rd}, {27'h0, m_rd});
    end

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic drive(input logic s, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic h, input logic [4:0] rd);
        bus.muldiv_start   = s;
        bus.muldiv_op      = op;
        bus.muldiv_a       = a;
        bus.muldiv_b       = b;
        bus.muldiv_hart_id = h;
        bus.muldiv_rd      = rd;
    endtask

    // Wait (bounded) for done; n is the cycle number of done counted from the accept edge.
    task automatic wait_done(input int limit, output int n);
        n = 1;
        while (!bus.muldiv_done && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Issue one op from idle (at a negedge) and check latency, result and tags against literals.
    task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic h, input logic [4:0] rd,
                         input logic [31:0] exp_res, input int exp_lat);
        int n;
        drive(1'b1, op, a, b, h, rd);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 3'($urandom), $urandom, $urandom, 1'($urandom), 5'($urandom));
        wait_done(40, n);
        chk({name, "_lat"}, n, exp_lat);
        chk({name, "_done"}, {31'h0, bus.muldiv_done}, 32'h1);
        chk({name, "_res"}, bus.muldiv_result, exp_res);
        chk({name, "_hart"}, {31'h0, bus.muldiv_done_hart_id}, {31'h0, h});
        chk({name, "_rd"}, {27'h0, bus.muldiv_done_rd}, {27'h0, rd});
        @(negedge clk);
        chk({name, "_idle"}, {31'h0, bus.muldiv_busy}, 32'h0);
        chk({name, "_hold"}, bus.muldiv_result, exp_res);
    endtask

    initial begin
        int n;
        int dn;
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 5'd0);
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'h0, bus.muldiv_busy}, 32'h0);
        chk("rst_done", {31'h0, bus.muldiv_done}, 32'h0);
        chk("rst_result", bus.muldiv_result, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 1'b1, 5'd5, 32'hFFFF_FFEB, 33);
        do_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 1'b0, 5'd1, 32'h4000_0000, 33);
        do_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5'd2, 32'hFFFF_FFFE, 33);
        do_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 5'd3, 32'hFFFF_FFFF, 33);
        do_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 1'b1, 5'd4, 32'hFFFF_FFFD, 33);
        do_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0, 5'd6, 32'hFFFF_FFFF, 33);
        do_op("divu", 3'd5, 32'd100, 32'd7, 1'b1, 5'd7, 32'd14, 33);
        do_op("remu", 3'd7, 32'd100, 32'd7, 1'b0, 5'd8, 32'd2, 33);
        do_op("divu_z", 3'd5, 32'd5, 32'd0, 1'b1, 5'd10, 32'hFFFF_FFFF, 1);
        do_op("rem_z", 3'd6, 32'd5, 32'd0, 1'b0, 5'd11, 32'd5, 1);
        do_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 5'd12, 32'h8000_0000, 1);
        do_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 5'd13, 32'h0, 1);

        // Start held high while busy: second request waits until the cycle after done.
        drive(1'b1, 3'd5, 32'd100, 32'd7, 1'b1, 5'd3);
        @(posedge clk);
        @(negedge clk);
        drive(1'b1, 3'd0, 32'd3, 32'd4, 1'b0, 5'd9);
        wait_done(40, n);
        chk("hold1_lat", n, 33);
        chk("hold1_res", bus.muldiv_result, 32'd14);
        chk("hold1_hart", {31'h0, bus.muldiv_done_hart_id}, 32'h1);
        chk("hold1_rd", {27'h0, bus.muldiv_done_rd}, 32'd3);
        @(negedge clk);
        chk("hold_gap_busy", {31'h0, bus.muldiv_busy}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 5'd0);
        wait_done(40, n);
        chk("hold2_lat", n, 33);
        chk("hold2_res", bus.muldiv_result, 32'd12);
        chk("hold2_hart", {31'h0, bus.muldiv_done_hart_id}, 32'h0);
        chk("hold2_rd", {27'h0, bus.muldiv_done_rd}, 32'd9);
        @(negedge clk);

        // Reset in the middle of a divide.
        drive(1'b1, 3'd4, 32'hFFFF_0000, 32'd3, 1'b1, 5'd20);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 5'd0);
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'h0, bus.muldiv_busy}, 32'h0);
        chk("midrst_done", {31'h0, bus.muldiv_done}, 32'h0);
        chk("midrst_result", bus.muldiv_result, 32'h0);
        chk("midrst_rd", {27'h0, bus.muldiv_done_rd}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.muldiv_done) dn++;
        end
        chk("midrst_no_done", dn, 0);
        do_op("post_rst", 3'd5, 32'd1000, 32'd10, 1'b1, 5'd31, 32'd100, 33);

        // Randomized traffic; the every-cycle compare carries the checking.
        repeat (3000) begin
            @(negedge clk);
            drive(1'($urandom_range(0, 1)), 3'($urandom), pick_operand(), pick_operand(),
                  1'($urandom), 5'($urandom));
        end
        @(negedge clk);
        drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 5'd0);
        repeat (40) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
